// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-side memory/MMIO responder:
// MMIO register offsets, STATUS bit positions and UART transmitter states.
package dmem_mmio_pkg;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] DONE_OFF   = 4'h8;
    localparam logic [3:0] CYCLES_OFF = 4'hC;

    // STATUS register bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_DONE  = 3;
    localparam int STAT_OVF   = 4;

    // UART transmitter frame phases
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter. Accepts one byte per frame over a valid/ready
// handshake; ready is raised in IDLE and on the last STOP cycle so that a
// waiting byte starts the next frame with no idle gap.
module uart_tx_core
    import dmem_mmio_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    uart_state_t state, state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_last;
    logic          accept;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);

    // State register
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state, handshake and line level
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = START;
            end
            START: begin
                tx = 1'b0;
                if (baud_last) state_next = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (baud_last && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                tx = 1'b1;
                if (baud_last) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud timer, bit counter and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (state == IDLE || baud_last) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + BW'(1);

            if (state == DATA && baud_last) bit_cnt <= bit_cnt + 3'd1;

            if (accept)                          shreg <= in_data;
            else if (state == DATA && baud_last) shreg <= {1'b0, shreg[7:1]};
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data memory port responder for the single-cycle core: word RAM plus a
// 16-byte MMIO window (UART TX FIFO, STATUS, sticky DONE, CYCLES).
// Reads are combinational; writes commit on the rising edge.
// Optional: define MMIO_CYCLE_CNT_EN to implement the CYCLES counter.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h0200_0000,
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic        done,
    output logic        tx_busy
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // ---------------- Address decode ----------------
    logic          sel_ram, sel_mmio;
    logic [3:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          ram_we, push_req, stat_wr, done_wr;
    logic          unused_addr_bits;

    assign sel_mmio = (Mem_WrAddr[31:4] == MMIO_BASE[31:4]);
    assign sel_ram  = (Mem_WrAddr[31:24] == 8'h00) && !sel_mmio;
    assign mmio_off = {Mem_WrAddr[3:2], 2'b00};
    assign ram_idx  = Mem_WrAddr[AW+1:2];
    assign unused_addr_bits = &{1'b0, Mem_WrAddr[1:0]};

    assign ram_we   = MemWrite && sel_ram;
    assign push_req = MemWrite && sel_mmio && (mmio_off == TXDATA_OFF);
    assign stat_wr  = MemWrite && sel_mmio && (mmio_off == STATUS_OFF);
    assign done_wr  = MemWrite && sel_mmio && (mmio_off == DONE_OFF);

    // ---------------- Data RAM ----------------
    logic [31:0] ram [RAM_WORDS];

    // RAM write port
    // NOTE: storage arrays carry no reset so they map onto RAM macros; software initialises them.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= Mem_WrData;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          pop, push_ok, tx_ready, uart_busy;
    logic          overflow;

    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = tx_ready && !fifo_empty;
    // A full FIFO still takes a byte when the transmitter pops on the same edge
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= Mem_WrData[7:0];
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_req && !push_ok)               overflow <= 1'b1;
            else if (stat_wr && Mem_WrData[STAT_OVF]) overflow <= 1'b0;
        end
    end

    uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk      (clk),
        .reset    (reset),
        .in_valid (!fifo_empty),
        .in_data  (fifo_mem[rd_ptr]),
        .in_ready (tx_ready),
        .tx       (uart_tx),
        .busy     (uart_busy)
    );

    assign tx_busy = uart_busy || !fifo_empty;

    // ---------------- DONE flag ----------------
    // Sticky completion flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       done <= 1'b0;
        else if (done_wr) done <= 1'b1;
    end

    // ---------------- Cycle counter ----------------
    logic [31:0] cyc_rd;
`ifdef MMIO_CYCLE_CNT_EN
    logic        cyc_wr;
    logic [31:0] cyc_cnt;
    assign cyc_wr = MemWrite && sel_mmio && (mmio_off == CYCLES_OFF);

    // Free-running counter, zeroed by any write to CYCLES
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cyc_cnt <= '0;
        else if (cyc_wr) cyc_cnt <= '0;
        else             cyc_cnt <= cyc_cnt + 32'd1;
    end
    assign cyc_rd = cyc_cnt;
`else
    assign cyc_rd = '0;
`endif

    // ---------------- Read mux ----------------
    logic [31:0] status_word;

    // STATUS register image
    always_comb begin
        status_word             = '0;
        status_word[STAT_BUSY]  = tx_busy;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_DONE]  = done;
        status_word[STAT_OVF]   = overflow;
    end

    // Combinational read data; the RAM returns its pre-edge contents
    always_comb begin
        ReadData = '0;
        if (sel_mmio) begin
            case (mmio_off)
                STATUS_OFF: ReadData = status_word;
                DONE_OFF:   ReadData = {31'b0, done};
                CYCLES_OFF: ReadData = cyc_rd;
                default:    ReadData = '0;
            endcase
        end else if (sel_ram) begin
            ReadData = ram[ram_idx];
        end
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-side bus responder for the single-cycle RISC-V core. It sits on the core's data memory port: MemWrite, Mem_WrAddr, Mem_WrData in, ReadData out.
- Provides word-addressed data RAM and a small MMIO window: UART transmit FIFO, status register, sticky "done" flag, and cycle counter.
- Reads are combinational, as the single-cycle core requires; writes commit on the rising clock edge.

Parameters:
- RAM_WORDS, 1024: data RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'h02000000: base of the 16-byte MMIO window.
- BAUD_DIV, 434: clock cycles per UART bit (50 MHz / 115200).
- FIFO_DEPTH, 4: TX FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  write strobe from core.
- Mem_WrAddr  in  32  byte address; bits [1:0] ignored.
- Mem_WrData  in  32  write data.
- ReadData  out  32  combinational read data for Mem_WrAddr.
- uart_tx  out  1  serial 8N1 line; idle high.
- done  out  1  sticky completion flag.
- tx_busy  out  1  high while a frame is being shifted or the FIFO is non-empty.

Behaviour:
- Reset values: uart_tx=1, done=0, tx_busy=0, FIFO empty, overflow=0, cycle counter=0. RAM contents are not reset.
- Decode:
  - Mem_WrAddr[31:24]==0 selects RAM. Index is addr[log2(RAM_WORDS)+1:2], so addresses alias past the end.
  - addr[31:4]==MMIO_BASE[31:4] selects MMIO.
  - Any other address reads 0; writes to it are ignored.
- MMIO offsets:
  - 0x0 TXDATA. Write pushes Mem_WrData[7:0]. Reads 0.
  - 0x4 STATUS. Read-only: bit0 tx_busy, bit1 fifo_full, bit2 fifo_empty, bit3 done, bit4 overflow. Writing 1 to bit4 clears overflow.
  - 0x8 DONE. Any write sets done, which stays set until reset. Reads {31'b0, done}.
  - 0xC CYCLES. Read returns the free-running 32-bit counter (wraps 0xFFFFFFFF to 0). Any write clears it to 0 on that edge.
- FIFO:
  - A push when full is dropped and sets overflow.
  - A push and a pop in the same cycle while full are both accepted (pop first), so count is unchanged.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on the first edge where the FIFO is non-empty; pop happens on that edge.
  - Each state lasts BAUD_DIV cycles. START drives 0. DATA shifts 8 bits LSB-first. STOP drives 1.
  - From STOP: go to START if the FIFO is non-empty (no idle gap), else to IDLE.
  - Frame length is exactly 10*BAUD_DIV cycles.
  - Latency: a TXDATA write at edge N gives a falling start bit after edge N+1.
- RAM write and ReadData: a write updates the RAM on the edge. A read of the same word in the same cycle returns the old value.
- Reset mid-frame: uart_tx returns high immediately and the FIFO is flushed.

Optional Feature:
- MMIO_CYCLE_CNT_EN.
  - Defined: CYCLES register implemented as described above.
  - Undefined: no counter flops. Offset 0xC reads 0 and writes to it are ignored.

Decomposition:
- Package dmem_mmio_pkg holds:
  - offset constants TXDATA_OFF/STATUS_OFF/DONE_OFF/CYCLES_OFF;
  - STATUS bit indices;
  - UART state enum (IDLE, START, DATA, STOP).
- One sub-module: uart_tx_core. It contains the FSM, baud counter and bit counter, with a valid/ready byte input fed from the FIFO.
- FIFO and decode logic stay in the top module.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 → 0xDEADBEEF. Read 0x00000010 + RAM_WORDS*4 → 0xDEADBEEF (alias).
- UART frame (BAUD_DIV=4): write 0x55 to 0x02000000 at edge N.
  - uart_tx low for cycles N+1..N+4.
  - Then bits 1,0,1,0,1,0,1,0, each 4 cycles.
  - Then high 4 cycles; tx_busy falls after cycle N+40.
- Back-to-back and overflow: write 6 bytes on consecutive cycles with FIFO_DEPTH=4.
  - First pop frees one slot, so 5 bytes are accepted; the 6th is dropped and STATUS reads bit4=1.
  - Frames are contiguous with no idle high between stop and start.
  - Writing 0x10 to STATUS clears bit4.
- Done: write 0x1 to 0x02000008 → done=1 on the next cycle, STATUS bit3=1, DONE reads 1. Only reset clears it.
- Cycle counter (macro defined): write to 0x0200000C, then read 5 cycles later → 5.
  - With the macro undefined, the read returns 0.
- Reset mid-frame: assert reset during the DATA state → uart_tx=1 immediately. After release, FIFO is empty, STATUS reads 0x4 and no further frame is sent.
